// File: rtl/risc_pkg.sv
// Shared definitions for the 16-bit RISC core: opcodes, FSM states, IR field
// positions and write-data mux encodings.
package risc_pkg;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_OR   = 4'h4;
    localparam logic [3:0] OP_XOR  = 4'h5;
    localparam logic [3:0] OP_LDI  = 4'h6;
    localparam logic [3:0] OP_JMP  = 4'h7;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam int IR_OP_HI  = 15;
    localparam int IR_OP_LO  = 12;
    localparam int IR_ALU_HI = 14;
    localparam int IR_RD_HI  = 11;
    localparam int IR_RD_LO  = 8;
    localparam int IR_RP_HI  = 7;
    localparam int IR_RP_LO  = 4;
    localparam int IR_RQ_HI  = 3;
    localparam int IR_RQ_LO  = 0;
    localparam int IR_IMM_HI = 7;
    localparam int IR_TGT_HI = 11;

    localparam logic WR_SEL_ALU = 1'b0;
    localparam logic WR_SEL_IMM = 1'b1;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_READ   = 3'd2,
        ST_EXEC   = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_t;

    typedef enum logic [2:0] {
        CLS_NOP     = 3'd0,
        CLS_ALU     = 3'd1,
        CLS_LDI     = 3'd2,
        CLS_JMP     = 3'd3,
        CLS_HALT    = 3'd4,
        CLS_ILLEGAL = 3'd5
    } op_class_t;

endpackage

// File: rtl/risc_decoder.sv
// Combinational opcode classifier: maps the 4-bit opcode to the instruction
// class that steers the control FSM.
module risc_decoder
    import risc_pkg::*;
(
    input  logic [3:0] opcode,
    output op_class_t  op_class
);

    always_comb begin
        op_class = CLS_ILLEGAL;
        case (opcode)
            OP_NOP:                              op_class = CLS_NOP;
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: op_class = CLS_ALU;
            OP_LDI:                              op_class = CLS_LDI;
            OP_JMP:                              op_class = CLS_JMP;
            OP_HALT:                             op_class = CLS_HALT;
            default:                             op_class = CLS_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/risc_control_unit.sv
// Multicycle control unit: fetches over a valid handshake, owns the PC and
// sequences register-file reads, ALU select and write-back.
module risc_control_unit
    import risc_pkg::*;
#(
    parameter int              PC_W     = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic [PC_W-1:0] im_addr,
    output logic            im_rd,
    input  logic [15:0]     im_data,
    input  logic            im_valid,
    output logic            rf_read_Rp,
    output logic            rf_read_Rq,
    output logic            rf_write,
    output logic [3:0]      rf_reg_num_Rp,
    output logic [3:0]      rf_reg_num_Rq,
    output logic [3:0]      rf_reg_num_wr,
    output logic            wr_sel,
    output logic [15:0]     imm,
    output logic [2:0]      alu_op,
    output logic            illegal_op,
    output logic            halted,
    output logic [2:0]      fsm_state
);

    // Handshake: an instruction is accepted in the single cycle where im_rd
    // and im_valid are both high in FETCH; im_valid at any other time is ignored.
    state_t          state, state_nx;
    logic [15:0]     ir;
    logic [PC_W-1:0] pc, pc_nx;
    op_class_t       op_class;
    logic            fetch_ok;

    risc_decoder u_decoder (
        .opcode   (ir[IR_OP_HI:IR_OP_LO]),
        .op_class (op_class)
    );

    assign fetch_ok = im_rd && im_valid && (state == ST_FETCH);

    always_comb begin
        state_nx = state;
        pc_nx    = pc;
        case (state)
            ST_FETCH: begin
                if (fetch_ok) begin
                    state_nx = ST_DECODE;
                    pc_nx    = pc + PC_W'(1);
                end
            end
            ST_DECODE: begin
                case (op_class)
                    CLS_ALU:  state_nx = ST_READ;
                    CLS_LDI:  state_nx = ST_WB;
                    CLS_HALT: state_nx = ST_HALT;
                    CLS_JMP: begin
                        state_nx = ST_FETCH;
                        pc_nx    = PC_W'(ir[IR_TGT_HI:0]);
                    end
                    default:  state_nx = ST_FETCH;
                endcase
            end
            ST_READ: state_nx = ST_EXEC;
            ST_EXEC: state_nx = ST_WB;
            ST_WB:   state_nx = ST_FETCH;
            ST_HALT: state_nx = ST_HALT;
            default: state_nx = ST_FETCH;
        endcase
    end

    // Strobes are registered from the next state so each one lines up with
    // the cycle its state occupies, free of any path from the memory inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_FETCH;
            pc         <= RESET_PC;
            ir         <= '0;
            im_rd      <= 1'b0;
            rf_read_Rp <= 1'b0;
            rf_read_Rq <= 1'b0;
            rf_write   <= 1'b0;
            wr_sel     <= WR_SEL_ALU;
            alu_op     <= 3'b000;
            halted     <= 1'b0;
        end else begin
            state <= state_nx;
            pc    <= pc_nx;
            if (fetch_ok) begin
                ir <= im_data;
            end
            im_rd      <= (state_nx == ST_FETCH);
            rf_read_Rp <= (state_nx == ST_READ);
            rf_read_Rq <= (state_nx == ST_READ);
            rf_write   <= (state_nx == ST_WB);
            wr_sel     <= ((state_nx == ST_WB) && (op_class == CLS_LDI)) ? WR_SEL_IMM : WR_SEL_ALU;
            alu_op     <= ((state_nx == ST_EXEC) || (state_nx == ST_WB)) ? ir[IR_ALU_HI:IR_OP_LO] : 3'b000;
            halted     <= (state_nx == ST_HALT);
        end
    end

    assign illegal_op    = (state == ST_DECODE) && (op_class == CLS_ILLEGAL);
    assign im_addr       = pc;
    assign rf_reg_num_wr = ir[IR_RD_HI:IR_RD_LO];
    assign rf_reg_num_Rp = ir[IR_RP_HI:IR_RP_LO];
    assign rf_reg_num_Rq = ir[IR_RQ_HI:IR_RQ_LO];
    assign imm           = {8'h00, ir[IR_IMM_HI:0]};
    assign fsm_state     = state;

endmodule

// File: tb/tb_risc_control_unit.sv
// Scoreboard bench for risc_control_unit: directed instructions push expected
// output events; a negedge monitor pops and compares each observed event.
module tb_risc_control_unit;

    localparam int              PC_W     = 16;
    localparam logic [PC_W-1:0] RESET_PC = 16'hFFFE;
    localparam int              EW       = 45;

    logic            clk;
    logic            rst_n;
    logic [PC_W-1:0] im_addr;
    logic            im_rd;
    logic [15:0]     im_data;
    logic            im_valid;
    logic            rf_read_Rp, rf_read_Rq, rf_write;
    logic [3:0]      rf_reg_num_Rp, rf_reg_num_Rq, rf_reg_num_wr;
    logic            wr_sel;
    logic [15:0]     imm;
    logic [2:0]      alu_op;
    logic            illegal_op, halted;
    logic [2:0]      fsm_state;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_fetch = 0;
    logic [EW-1:0] exp_q[$];

    risc_control_unit #(.PC_W(PC_W), .RESET_PC(RESET_PC)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .im_addr       (im_addr),
        .im_rd         (im_rd),
        .im_data       (im_data),
        .im_valid      (im_valid),
        .rf_read_Rp    (rf_read_Rp),
        .rf_read_Rq    (rf_read_Rq),
        .rf_write      (rf_write),
        .rf_reg_num_Rp (rf_reg_num_Rp),
        .rf_reg_num_Rq (rf_reg_num_Rq),
        .rf_reg_num_wr (rf_reg_num_wr),
        .wr_sel        (wr_sel),
        .imm           (imm),
        .alu_op        (alu_op),
        .illegal_op    (illegal_op),
        .halted        (halted),
        .fsm_state     (fsm_state)
    );

    // clock / cycle counter
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    // event = {hs, read_p, read_q, write, illegal, dt, alu_op, wr_sel, regs, val}
    function automatic logic [EW-1:0] ev(logic hs, logic rd, logic wr, logic ill,
                                         logic [7:0] dt, logic [2:0] alu, logic ws,
                                         logic [11:0] regs, logic [15:0] val);
        return {hs, rd, rd, wr, ill, dt, alu, ws, regs, val};
    endfunction

    task automatic push_f(input logic [7:0] dt, input logic [15:0] addr);
        exp_q.push_back(ev(1'b1, 1'b0, 1'b0, 1'b0, dt, 3'd0, 1'b0, 12'h000, addr));
    endtask

    task automatic push_alu(input logic [11:0] regs, input logic [15:0] val, input logic [2:0] op);
        exp_q.push_back(ev(1'b0, 1'b1, 1'b0, 1'b0, 8'd2, 3'd0, 1'b0, regs, val));
        exp_q.push_back(ev(1'b0, 1'b0, 1'b0, 1'b0, 8'd3, op,   1'b0, regs, val));
        exp_q.push_back(ev(1'b0, 1'b0, 1'b1, 1'b0, 8'd4, op,   1'b0, regs, val));
    endtask

    task automatic push_ldi(input logic [11:0] regs, input logic [15:0] val);
        exp_q.push_back(ev(1'b0, 1'b0, 1'b1, 1'b0, 8'd2, 3'd6, 1'b1, regs, val));
    endtask

    task automatic push_ill(input logic [11:0] regs, input logic [15:0] val);
        exp_q.push_back(ev(1'b0, 1'b0, 1'b0, 1'b1, 8'd1, 3'd0, 1'b0, regs, val));
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h", name, act, req);
        end
    endtask

    // driver: junk with im_valid=1 while im_rd is low, then optional wait
    // cycles with random data and im_valid=0, then one accepted word
    task automatic fetch_instr(input logic [15:0] data, input int waits);
        int budget;
        budget = 0;
        while (im_rd !== 1'b1 && budget < 40) begin
            im_valid = 1'b1;
            im_data  = 16'h8ABC;
            @(posedge clk); #1;
            budget++;
        end
        if (im_rd !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL fetch_timeout: actual=im_rd_low required=im_rd_high");
        end
        for (int i = 0; i < waits; i++) begin
            im_valid = 1'b0;
            im_data  = 16'($urandom_range(0, 16'hFFFF));
            @(posedge clk); #1;
        end
        im_valid = 1'b1;
        im_data  = data;
        @(posedge clk); #1;
        im_valid = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_im_addr"}, 32'(im_addr), 32'(RESET_PC));
        chk({tag, "_strobes"}, {27'd0, im_rd, rf_read_Rp, rf_read_Rq, rf_write, illegal_op}, 32'd0);
        chk({tag, "_alu_op"}, 32'(alu_op), 32'd0);
        chk({tag, "_halted"}, 32'(halted), 32'd0);
        chk({tag, "_state"}, 32'(fsm_state), 32'd0);
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin
        logic          hs;
        logic [EW-1:0] act, req;
        if (!rst_n) begin
            last_fetch = 0;
        end else begin
            hs = im_rd && im_valid;
            if (hs || rf_read_Rp || rf_read_Rq || rf_write || illegal_op || alu_op != 3'd0) begin
                act = {hs, rf_read_Rp, rf_read_Rq, rf_write, illegal_op, 8'(cyc - last_fetch),
                       alu_op, wr_sel,
                       hs ? 12'h000 : {rf_reg_num_wr, rf_reg_num_Rp, rf_reg_num_Rq},
                       hs ? im_addr : imm};
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_event: actual=%h required=none", act);
                end else begin
                    req = exp_q.pop_front();
                    if (act !== req) begin
                        errors++;
                        $display("FAIL event: actual=%h required=%h", act, req);
                    end
                end
            end
            if (hs) last_fetch = cyc;
        end
    end

    initial begin
        rst_n    = 1'b0;
        im_valid = 1'b0;
        im_data  = 16'h0000;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;

        // ADD r1,r2,r3 zero-wait
        push_f(8'd1, 16'hFFFE);
        push_alu(12'h123, 16'h0023, 3'd1);
        fetch_instr(16'h1123, 0);
        // LDI r5,0xA7 at PC=0xFFFF
        push_f(8'd5, 16'hFFFF);
        push_ldi(12'h5A7, 16'h00A7);
        fetch_instr(16'h65A7, 0);
        // NOP at wrapped PC 0x0000
        push_f(8'd3, 16'h0000);
        fetch_instr(16'h0000, 0);
        // illegal with 3 wait cycles
        push_f(8'd5, 16'h0001);
        push_ill(12'hABC, 16'h00BC);
        fetch_instr(16'h9ABC, 3);
        // JMP 0x123
        push_f(8'd2, 16'h0002);
        fetch_instr(16'h7123, 0);
        // LDI at jump target
        push_f(8'd2, 16'h0123);
        push_ldi(12'h312, 16'h0012);
        fetch_instr(16'h6312, 0);
        // SUB with one wait cycle
        push_f(8'd4, 16'h0124);
        push_alu(12'h456, 16'h0056, 3'd2);
        fetch_instr(16'h2456, 1);
        // XOR with rd == rp
        push_f(8'd5, 16'h0125);
        push_alu(12'h334, 16'h0034, 3'd5);
        fetch_instr(16'h5334, 0);
        // HALT
        push_f(8'd5, 16'h0126);
        fetch_instr(16'hF000, 0);
        im_valid = 1'b1;
        im_data  = 16'h1123;
        @(posedge clk); #1;
        for (int i = 0; i < 20; i++) begin
            chk("halt_halted", 32'(halted), 32'd1);
            chk("halt_im_rd", 32'(im_rd), 32'd0);
            @(posedge clk); #1;
        end
        chk("halt_state", 32'(fsm_state), 32'd5);

        rst_n = 1'b0;
        #1;
        check_reset_outputs("halt_reset");
        @(posedge clk); #1;
        rst_n = 1'b1;

        // ADD aborted by reset during READ
        push_f(8'd1, 16'hFFFE);
        exp_q.push_back(ev(1'b0, 1'b1, 1'b0, 1'b0, 8'd2, 3'd0, 1'b0, 12'h123, 16'h0023));
        fetch_instr(16'h1123, 0);
        @(posedge clk); #6;
        chk("abort_in_read", 32'(rf_read_Rp), 32'd1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("abort");
        chk("abort_rf_write", 32'(rf_write), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        push_f(8'd1, 16'hFFFE);
        fetch_instr(16'h0000, 0);
        repeat (10) @(posedge clk);
        #1;
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
